rs_issue_sched: RTL and testbench

//  Issue scheduler between the reservation station (RS) and the shared ALU pool.

---
 rtl/rs_issue_sched.sv | 167 ++++++++++++++++
 tb/tb_rs_issue_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_sched.sv
// Round-robin issue scheduler between the reservation station and NUM_FU ALUs.
// Optional macro ISSUE_PERF_CNT_EN adds a saturating stall_cnt output.
module rs_issue_sched #(
  parameter int NUM_RS = 8,
  parameter int NUM_FU = 2,
  parameter int IDX_W  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    squash,
  input  logic [NUM_RS-1:0]       req,
  input  logic [NUM_FU-1:0]       fu_ready,
  output logic [NUM_FU-1:0]       grant_valid,
  output logic [NUM_FU*IDX_W-1:0] grant_idx,
  output logic [NUM_RS-1:0]       issue_ack
`ifdef ISSUE_PERF_CNT_EN
  , output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} fu_state_t;

  fu_state_t          state_r [NUM_FU];
  logic [IDX_W-1:0]   idx_r [NUM_FU];
  logic [IDX_W-1:0]   rr_ptr_r;

  logic [NUM_FU-1:0]  fire_s;
  logic [NUM_RS-1:0]  ack_s;
  logic [NUM_RS-1:0]  held_s;
  logic [NUM_RS-1:0]  cand_s;
  logic [NUM_FU-1:0]  pick_s;
  logic [IDX_W-1:0]   pick_idx_s [NUM_FU];
  logic [IDX_W-1:0]   rr_ptr_nxt_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if ({1'b0, v} == (IDX_W+1)'(NUM_RS - 1)) return '0;
    else return v + IDX_W'(1);
  endfunction

  // Handshakes, ack vector and round-robin candidate selection per FU
  always_comb begin : pick_blk
    logic [IDX_W:0] pos;
    pos          = '0;
    fire_s       = '0;
    ack_s        = '0;
    held_s       = '0;
    pick_s       = '0;
    rr_ptr_nxt_s = rr_ptr_r;
    for (int f = 0; f < NUM_FU; f++) begin
      pick_idx_s[f] = '0;
      fire_s[f] = (state_r[f] == ST_HOLD) & fu_ready[f] & en & ~squash & ~reset;
      if (fire_s[f]) ack_s[idx_r[f]] = 1'b1;
      else if (state_r[f] == ST_HOLD) held_s[idx_r[f]] = 1'b1;
      else held_s = held_s;
    end
    // An entry being acked this cycle is freed by the RS; never re-pick it.
    cand_s = req & ~held_s & ~ack_s;
    for (int f = 0; f < NUM_FU; f++) begin
      if ((state_r[f] == ST_IDLE) || fire_s[f]) begin
        for (int off = 0; off < NUM_RS; off++) begin
          pos = {1'b0, rr_ptr_r} + (IDX_W+1)'(off);
          if (pos >= (IDX_W+1)'(NUM_RS)) pos = pos - (IDX_W+1)'(NUM_RS);
          else pos = pos;
          if (!pick_s[f] && cand_s[pos[IDX_W-1:0]]) begin
            pick_s[f]     = 1'b1;
            pick_idx_s[f] = pos[IDX_W-1:0];
          end else begin
            pick_s[f] = pick_s[f];
          end
        end
        if (pick_s[f]) begin
          cand_s[pick_idx_s[f]] = 1'b0;
          rr_ptr_nxt_s          = wrap_inc(pick_idx_s[f]);
        end else begin
          cand_s = cand_s;
        end
      end else begin
        pick_s[f] = 1'b0;
      end
    end
  end

  // Per-FU IDLE/HOLD state, held index and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int f = 0; f < NUM_FU; f++) begin
        state_r[f] <= ST_IDLE;
        idx_r[f]   <= '0;
      end
      rr_ptr_r <= '0;
    end else if (squash) begin
      for (int f = 0; f < NUM_FU; f++) state_r[f] <= ST_IDLE;
    end else if (en) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if ((state_r[f] == ST_IDLE) || fire_s[f]) begin
          state_r[f] <= pick_s[f] ? ST_HOLD : ST_IDLE;
          if (pick_s[f]) idx_r[f] <= pick_idx_s[f];
        end
      end
      if (|pick_s) rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Flatten registered per-FU state onto the output ports
  always_comb begin
    grant_valid = '0;
    grant_idx   = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      grant_valid[f]                = (state_r[f] == ST_HOLD);
      grant_idx[f*IDX_W +: IDX_W]   = idx_r[f];
    end
  end

  assign issue_ack = ack_s;

`ifdef ISSUE_PERF_CNT_EN
  // Saturating count of enabled cycles where some pending grant is stalled
  always_ff @(posedge clock) begin
    if (reset) stall_cnt <= 32'd0;
    else if (en && (|(grant_valid & ~fu_ready)) && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  rs_issue_sched_chk #(.NUM_RS(NUM_RS), .NUM_FU(NUM_FU), .IDX_W(IDX_W)) u_chk (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .issue_ack   (issue_ack)
  );

endmodule

// Protocol and invariant checks for the issue scheduler.
module rs_issue_sched_chk #(
  parameter int NUM_RS = 8,
  parameter int NUM_FU = 2,
  parameter int IDX_W  = 3
) (
  input logic                    clock,
  input logic                    reset,
  input logic [NUM_RS-1:0]       req,
  input logic [NUM_FU-1:0]       grant_valid,
  input logic [NUM_FU*IDX_W-1:0] grant_idx,
  input logic [NUM_RS-1:0]       issue_ack
);

  // RS must keep req up for held entries; no entry held twice; acks bounded
  always @(posedge clock) begin
    if (!reset) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (grant_valid[f])
          assert (req[grant_idx[f*IDX_W +: IDX_W]])
          else $error("req dropped for held entry %0d (fu %0d)", grant_idx[f*IDX_W +: IDX_W], f);
        for (int g = f + 1; g < NUM_FU; g++)
          if (grant_valid[f] && grant_valid[g])
            assert (grant_idx[f*IDX_W +: IDX_W] != grant_idx[g*IDX_W +: IDX_W])
            else $error("entry held by fu %0d and fu %0d", f, g);
      end
      assert ($countones(issue_ack) <= NUM_FU) else $error("too many acks: %b", issue_ack);
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed + random bench for rs_issue_sched against a queue/array-level reference model.
module tb_rs_issue_sched;

  logic       clock = 1'b0;
  logic       reset, en, squash;
  logic [7:0] req;
  logic [1:0] fu_ready;
  logic [1:0] grant_valid;
  logic [5:0] grant_idx;
  logic [7:0] issue_ack;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clock = ~clock;

  rs_issue_sched #(.NUM_RS(8), .NUM_FU(2), .IDX_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .squash      (squash),
    .req         (req),
    .fu_ready    (fu_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .issue_ack   (issue_ack)
`ifdef ISSUE_PERF_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which RS entry each FU owns, and where the search starts.
  bit          m_busy [2];
  int          m_entry [2];
  int          m_start;
  longint      m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_ack();
    logic [7:0] a = 8'd0;
    for (int f = 0; f < 2; f++)
      if (m_busy[f] && fu_ready[f] && en && !squash && !reset) a[m_entry[f]] = 1'b1;
    return a;
  endfunction

  task automatic model_step();
    bit free_slot [8];
    bit accepted [2];
    int last = -1;
    if (reset) begin
      for (int f = 0; f < 2; f++) begin m_busy[f] = 0; m_entry[f] = 0; end
      m_start = 0;
      m_stall = 0;
      return;
    end
    if (en && ((m_busy[0] && !fu_ready[0]) || (m_busy[1] && !fu_ready[1])) && m_stall < 64'hFFFF_FFFF)
      m_stall++;
    if (squash) begin
      m_busy[0] = 0; m_busy[1] = 0;
      return;
    end
    if (!en) return;
    for (int i = 0; i < 8; i++) free_slot[i] = req[i];
    for (int f = 0; f < 2; f++) begin
      accepted[f] = m_busy[f] && fu_ready[f];
      if (m_busy[f]) free_slot[m_entry[f]] = 0;
    end
    for (int f = 0; f < 2; f++) begin
      if (m_busy[f] && !accepted[f]) continue;
      m_busy[f] = 0;
      for (int k = 0; k < 8; k++) begin
        int e = (m_start + k) % 8;
        if (free_slot[e]) begin
          m_busy[f] = 1; m_entry[f] = e; free_slot[e] = 0; last = e;
          break;
        end
      end
    end
    if (last >= 0) m_start = (last + 1) % 8;
  endtask

  // One clock: check ack before the edge, advance model, check grants after the edge.
  task automatic step(input string tag);
    logic [7:0] ack_exp;
    #1;
    ack_exp = model_ack();
    check({tag, "_ack"}, 32'(issue_ack), 32'(ack_exp));
    model_step();
    @(posedge clock);
    #1;
    check({tag, "_gv"}, 32'(grant_valid), {30'd0, m_busy[1], m_busy[0]});
    for (int f = 0; f < 2; f++)
      if (m_busy[f]) check({tag, "_idx"}, 32'(grant_idx[f*3 +: 3]), 32'(m_entry[f]));
`ifdef ISSUE_PERF_CNT_EN
    check({tag, "_stall"}, stall_cnt, 32'(m_stall));
`endif
    @(negedge clock);
    req = req & ~ack_exp;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; squash = 1'b0; req = 8'h00; fu_ready = 2'b00;
    m_start = 0; m_stall = 0;
    @(negedge clock);
    step("reset");
    step("reset");
    check("reset_gv", 32'(grant_valid), 32'd0);
    check("reset_idx", 32'(grant_idx), 32'd0);
`ifdef ISSUE_PERF_CNT_EN
    check("reset_stall", stall_cnt, 32'd0);
`endif

    // single requester at idx 2
    reset = 1'b0; en = 1'b1; req = 8'b0000_0100; fu_ready = 2'b11;
    step("t1_pick");
    check("t1_gv", 32'(grant_valid), 32'd1);
    check("t1_idx0", 32'(grant_idx[2:0]), 32'd2);
    #1 check("t1_ack_lit", 32'(issue_ack), 32'h04);
    step("t1_fire");

    // move the pointer to 6 via entry 5
    req = 8'h20; fu_ready = 2'b00;
    step("t2_prep");
    fu_ready = 2'b01;
    step("t2_prep_fire");

    // all requesting from pointer 6, FUs stalled
    req = 8'hFF; fu_ready = 2'b00;
    step("t2_load");
    check("t2_gv", 32'(grant_valid), 32'd3);
    check("t2_idx0", 32'(grant_idx[2:0]), 32'd6);
    check("t2_idx1", 32'(grant_idx[5:3]), 32'd7);
    for (int i = 0; i < 3; i++) begin
      #1 check("t2_hold_ack", 32'(issue_ack), 32'd0);
      step("t2_hold");
    end
    fu_ready = 2'b11;
    #1 check("t2_ack_lit", 32'(issue_ack), 32'hC0);
    step("t2_fire");
    check("t2_next_idx0", 32'(grant_idx[2:0]), 32'd0);
    check("t2_next_idx1", 32'(grant_idx[5:3]), 32'd1);

    // FU0 back-to-back, FU1 stalled
    fu_ready = 2'b01;
    for (int i = 0; i < 4; i++) step("t3_b2b");

    // squash with both FUs ready
    req = req | 8'h81; fu_ready = 2'b00;
    step("t4_load");
    squash = 1'b1; fu_ready = 2'b11;
    #1 check("t4_ack_lit", 32'(issue_ack), 32'd0);
    step("t4_squash");
    check("t4_gv_lit", 32'(grant_valid), 32'd0);
    squash = 1'b0;

    // frozen by en=0
    fu_ready = 2'b00;
    step("t5_load");
    en = 1'b0; fu_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 check("t5_frozen_ack", 32'(issue_ack), 32'd0);
      step("t5_frozen");
    end
    en = 1'b1;
    #1 check("t5_resume_ack", 32'(issue_ack != 8'd0), 32'd1);
    step("t5_resume");

    // reset in the middle of a hold
    req = req | 8'h18; fu_ready = 2'b00;
    step("t6_hold");
    reset = 1'b1; fu_ready = 2'b11;
    #1 check("t6_ack_lit", 32'(issue_ack), 32'd0);
    step("t6_reset");
    check("t6_gv_lit", 32'(grant_valid), 32'd0);
    check("t6_idx_lit", 32'(grant_idx), 32'd0);
    reset = 1'b0;

    // five stalled enabled cycles
    req = 8'hFF; fu_ready = 2'b00;
    step("t7_load");
    for (int i = 0; i < 5; i++) step("t7_stall");
`ifdef ISSUE_PERF_CNT_EN
    check("t7_stall_lit", stall_cnt, 32'd5);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req      = req | 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      fu_ready = 2'($urandom_range(0, 3));
      en       = ($urandom_range(0, 9) != 0);
      squash   = ($urandom_range(0, 19) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
